mem_port_arbiter: RTL and testbench

Near-memory port controller directly downstream of the compute unit's memory read/write interfaces. It arbitrates between the CU port and a host/DMA port and serialises all accesses onto one single-port synchronous SRAM bank, returning read data and write acknowledgements through the same req/valid and req/ack handshakes the CU uses. One access is in flight at a time. Out-of-range addresses are flagged and handled safely.

---
 rtl/mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CU port and a host/DMA port onto one single-port synchronous SRAM bank.
// Only one access is in flight at a time. Out-of-range accesses complete without touching the SRAM and set a sticky error.
module mem_port_arbiter #(
    parameter int addr_width   = 12,
    parameter int read_latency = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cu_read_req,
    input  logic [31:0]           cu_read_addr,
    output logic                  cu_read_valid,
    output logic [31:0]           cu_read_data,
    input  logic                  cu_write_req,
    input  logic [31:0]           cu_write_addr,
    input  logic [31:0]           cu_write_data,
    output logic                  cu_write_ack,
    input  logic                  host_read_req,
    input  logic [31:0]           host_read_addr,
    output logic                  host_read_valid,
    output logic [31:0]           host_read_data,
    input  logic                  host_write_req,
    input  logic [31:0]           host_write_addr,
    input  logic [31:0]           host_write_data,
    output logic                  host_write_ack,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [addr_width-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  port_q, port_d;        // 0 = CU, 1 = host
    logic                  op_q, op_d;            // 1 = write
    logic                  oor_q, oor_d;
    logic                  prio_q, prio_d;        // 1 = host wins the next contention
    logic                  mask_vld_q, mask_vld_d;
    logic                  mask_port_q, mask_port_d;
    logic                  mask_op_q, mask_op_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  cu_read_valid_q, cu_read_valid_d;
    logic [31:0]           cu_read_data_q, cu_read_data_d;
    logic                  cu_write_ack_q, cu_write_ack_d;
    logic                  host_read_valid_q, host_read_valid_d;
    logic [31:0]           host_read_data_q, host_read_data_d;
    logic                  host_write_ack_q, host_write_ack_d;
    logic                  sram_en_q, sram_en_d;
    logic                  sram_we_q, sram_we_d;
    logic [addr_width-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]           sram_wdata_q, sram_wdata_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  cu_wr_s, cu_rd_s, host_wr_s, host_rd_s;
    logic                  cu_any_s, host_any_s, gnt_host_s, gnt_op_s, gnt_oor_s;
    logic [31:0]           gnt_addr_s, gnt_wdata_s, rdat_s;

    // Eligible request lines after the cooldown mask, and the round-robin grant
    always_comb begin
        cu_wr_s    = cu_write_req   && !(mask_vld_q && !mask_port_q &&  mask_op_q);
        cu_rd_s    = cu_read_req    && !(mask_vld_q && !mask_port_q && !mask_op_q);
        host_wr_s  = host_write_req && !(mask_vld_q &&  mask_port_q &&  mask_op_q);
        host_rd_s  = host_read_req  && !(mask_vld_q &&  mask_port_q && !mask_op_q);
        cu_any_s   = cu_wr_s || cu_rd_s;
        host_any_s = host_wr_s || host_rd_s;
        gnt_host_s = host_any_s && (!cu_any_s || prio_q);
        if (gnt_host_s) begin
            gnt_op_s    = host_wr_s;
            gnt_addr_s  = host_wr_s ? host_write_addr : host_read_addr;
            gnt_wdata_s = host_write_data;
        end else begin
            gnt_op_s    = cu_wr_s;
            gnt_addr_s  = cu_wr_s ? cu_write_addr : cu_read_addr;
            gnt_wdata_s = cu_write_data;
        end
        gnt_oor_s = (gnt_addr_s >> addr_width) != 32'd0;
        rdat_s    = oor_q ? 32'd0 : sram_rdata;
    end

    // Sticky range error where a new error wins over a simultaneous clear
    always_comb begin
        if ((state_q == S_ISSUE) && oor_q) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Next-state and registered-output computation for the access sequencer
    always_comb begin
        state_d           = state_q;
        port_d            = port_q;
        op_d              = op_q;
        oor_d             = oor_q;
        prio_d            = prio_q;
        mask_vld_d        = mask_vld_q;
        mask_port_d       = mask_port_q;
        mask_op_d         = mask_op_q;
        cnt_d             = cnt_q;
        cu_read_valid_d   = 1'b0;
        cu_read_data_d    = cu_read_data_q;
        cu_write_ack_d    = 1'b0;
        host_read_valid_d = 1'b0;
        host_read_data_d  = host_read_data_q;
        host_write_ack_d  = 1'b0;
        sram_en_d         = 1'b0;
        sram_we_d         = 1'b0;
        sram_addr_d       = sram_addr_q;
        sram_wdata_d      = sram_wdata_q;
        case (state_q)
            S_IDLE: begin
                mask_vld_d = 1'b0;
                if (cu_any_s || host_any_s) begin
                    state_d      = S_ISSUE;
                    port_d       = gnt_host_s;
                    op_d         = gnt_op_s;
                    oor_d        = gnt_oor_s;
                    prio_d       = !gnt_host_s;
                    sram_en_d    = !gnt_oor_s;
                    sram_we_d    = gnt_op_s && !gnt_oor_s;
                    sram_addr_d  = gnt_addr_s[addr_width-1:0];
                    sram_wdata_d = gnt_wdata_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (op_q) begin
                    state_d          = S_RESP;
                    cu_write_ack_d   = !port_q;
                    host_write_ack_d = port_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(read_latency);
                end
            end
            S_WAIT: begin
                // The count reaches one on the cycle the SRAM presents the read word
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                    if (port_q) begin
                        host_read_valid_d = 1'b1;
                        host_read_data_d  = rdat_s;
                    end else begin
                        cu_read_valid_d = 1'b1;
                        cu_read_data_d  = rdat_s;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                mask_vld_d  = 1'b1;
                mask_port_d = port_q;
                mask_op_d   = op_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= S_IDLE;
            port_q            <= 1'b0;
            op_q              <= 1'b0;
            oor_q             <= 1'b0;
            prio_q            <= 1'b0;
            mask_vld_q        <= 1'b0;
            mask_port_q       <= 1'b0;
            mask_op_q         <= 1'b0;
            cnt_q             <= 3'd0;
            cu_read_valid_q   <= 1'b0;
            cu_read_data_q    <= 32'd0;
            cu_write_ack_q    <= 1'b0;
            host_read_valid_q <= 1'b0;
            host_read_data_q  <= 32'd0;
            host_write_ack_q  <= 1'b0;
            sram_en_q         <= 1'b0;
            sram_we_q         <= 1'b0;
            sram_addr_q       <= '0;
            sram_wdata_q      <= 32'd0;
            busy_q            <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            port_q            <= port_d;
            op_q              <= op_d;
            oor_q             <= oor_d;
            prio_q            <= prio_d;
            mask_vld_q        <= mask_vld_d;
            mask_port_q       <= mask_port_d;
            mask_op_q         <= mask_op_d;
            cnt_q             <= cnt_d;
            cu_read_valid_q   <= cu_read_valid_d;
            cu_read_data_q    <= cu_read_data_d;
            cu_write_ack_q    <= cu_write_ack_d;
            host_read_valid_q <= host_read_valid_d;
            host_read_data_q  <= host_read_data_d;
            host_write_ack_q  <= host_write_ack_d;
            sram_en_q         <= sram_en_d;
            sram_we_q         <= sram_we_d;
            sram_addr_q       <= sram_addr_d;
            sram_wdata_q      <= sram_wdata_d;
            busy_q            <= busy_d;
            err_q             <= err_d;
        end
    end

    assign cu_read_valid   = cu_read_valid_q;
    assign cu_read_data    = cu_read_data_q;
    assign cu_write_ack    = cu_write_ack_q;
    assign host_read_valid = host_read_valid_q;
    assign host_read_data  = host_read_data_q;
    assign host_write_ack  = host_write_ack_q;
    assign sram_en         = sram_en_q;
    assign sram_we         = sram_we_q;
    assign sram_addr       = sram_addr_q;
    assign sram_wdata      = sram_wdata_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: an SRAM environment, a transaction-level timing model checked every cycle,
// and directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int AW = 12;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cu_read_req, cu_write_req, host_read_req, host_write_req, err_clr;
    logic [31:0]   cu_read_addr, cu_write_addr, cu_write_data;
    logic [31:0]   host_read_addr, host_write_addr, host_write_data;
    logic          cu_read_valid, cu_write_ack, host_read_valid, host_write_ack;
    logic [31:0]   cu_read_data, host_read_data;
    logic          sram_en, sram_we, busy, err;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;
    logic          env_init;

    always #5 clk = ~clk;

    mem_port_arbiter #(.addr_width(AW), .read_latency(RL)) dut (
        .clk(clk), .rstn(rstn),
        .cu_read_req(cu_read_req), .cu_read_addr(cu_read_addr),
        .cu_read_valid(cu_read_valid), .cu_read_data(cu_read_data),
        .cu_write_req(cu_write_req), .cu_write_addr(cu_write_addr),
        .cu_write_data(cu_write_data), .cu_write_ack(cu_write_ack),
        .host_read_req(host_read_req), .host_read_addr(host_read_addr),
        .host_read_valid(host_read_valid), .host_read_data(host_read_data),
        .host_write_req(host_write_req), .host_write_addr(host_write_addr),
        .host_write_data(host_write_data), .host_write_ack(host_write_ack),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return 32'h5A00_0000 | 32'(a);
    endfunction

    // SRAM environment: writes take effect at the strobe edge, read words appear RL cycles after the strobe
    logic [31:0] env_mem [0:(1<<AW)-1];
    logic [31:0] pipe_d  [1:RL];
    logic        pipe_v  [1:RL];
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < (1 << AW); i++) env_mem[i] <= init_val(i);
            for (int i = 1; i <= RL; i++) pipe_v[i] <= 1'b0;
        end else begin
            if (sram_en && sram_we) env_mem[sram_addr] <= sram_wdata;
            pipe_d[1] <= env_mem[sram_addr];
            pipe_v[1] <= sram_en && !sram_we;
            for (int i = 2; i <= RL; i++) begin
                pipe_d[i] <= pipe_d[i-1];
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end
    assign sram_rdata = pipe_v[RL] ? pipe_d[RL] : 32'hDEAD_BEEF;

    // Transaction-level model: one record per granted op, with outputs derived from its issue cycle
    logic [31:0] mdl_mem [0:(1<<AW)-1];
    int          cyc = 0, t_iss = 0, t_end = -1, cool_cyc = -1, cool_line = 0;
    bit          has_op = 0, m_port = 0, m_op = 0, m_oor = 0, m_prio = 0, m_err = 0;
    bit          active, exp_en, cu_ok, h_ok;
    bit          rq [4];
    logic [31:0] m_addr, m_wdata, rd_cu = 32'd0, rd_host = 32'd0;
    int          n_strobe = 0, n_cuv = 0, n_hv = 0;
    int          order [$];

    initial begin
        forever begin
            @(negedge clk);
            if (env_init) for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = init_val(i);
            if (sram_en) n_strobe++;
            if (cu_read_valid) begin n_cuv++; order.push_back(0); end
            if (host_read_valid) begin n_hv++; order.push_back(1); end
            if (!rstn) begin
                chk("rst_flags", 32'({cu_read_valid, cu_write_ack, host_read_valid, host_write_ack,
                                      sram_en, sram_we, busy, err}), 32'd0);
                chk("rst_cu_data", cu_read_data, 32'd0);
                chk("rst_host_data", host_read_data, 32'd0);
                chk("rst_sram_addr", 32'(sram_addr), 32'd0);
                chk("rst_sram_wdata", sram_wdata, 32'd0);
                has_op = 0; m_prio = 0; m_err = 0; cool_cyc = -1;
                rd_cu = 32'd0; rd_host = 32'd0;
            end else begin
                active = has_op && (cyc <= t_end);
                exp_en = active && (cyc == t_iss + 1) && !m_oor;
                chk("m_sram_en", 32'(sram_en), 32'(exp_en));
                if (exp_en) begin
                    chk("m_sram_we", 32'(sram_we), 32'(m_op));
                    chk("m_sram_addr", 32'(sram_addr), m_addr);
                    if (m_op) chk("m_sram_wdata", sram_wdata, m_wdata);
                end
                chk("m_busy", 32'(busy), 32'(active && (cyc > t_iss)));
                chk("m_cu_wack", 32'(cu_write_ack), 32'(active && m_op && !m_port && (cyc == t_iss + 2)));
                chk("m_host_wack", 32'(host_write_ack), 32'(active && m_op && m_port && (cyc == t_iss + 2)));
                chk("m_cu_rvalid", 32'(cu_read_valid), 32'(active && !m_op && !m_port && (cyc == t_iss + 2 + RL)));
                chk("m_host_rvalid", 32'(host_read_valid), 32'(active && !m_op && m_port && (cyc == t_iss + 2 + RL)));
                chk("m_cu_rdata", cu_read_data, rd_cu);
                chk("m_host_rdata", host_read_data, rd_host);
                chk("m_err", 32'(err), 32'(m_err));
                if (active && (cyc == t_iss + 1) && m_oor) m_err = 1;
                else if (err_clr) m_err = 0;
                if (exp_en && m_op) mdl_mem[m_addr[AW-1:0]] = m_wdata;
                if (active && !m_op && (cyc == t_iss + 1 + RL)) begin
                    if (m_port) rd_host = m_oor ? 32'd0 : mdl_mem[m_addr[AW-1:0]];
                    else        rd_cu   = m_oor ? 32'd0 : mdl_mem[m_addr[AW-1:0]];
                end
                if (!active) begin
                    rq[0] = cu_read_req; rq[1] = cu_write_req;
                    rq[2] = host_read_req; rq[3] = host_write_req;
                    if (cyc == cool_cyc) rq[cool_line] = 0;
                    cu_ok = rq[0] || rq[1];
                    h_ok  = rq[2] || rq[3];
                    if (cu_ok || h_ok) begin
                        m_port  = h_ok && (!cu_ok || m_prio);
                        m_prio  = !m_port;
                        m_op    = m_port ? rq[3] : rq[1];
                        m_addr  = m_port ? (m_op ? host_write_addr : host_read_addr)
                                         : (m_op ? cu_write_addr : cu_read_addr);
                        m_wdata = m_port ? host_write_data : cu_write_data;
                        m_oor   = m_addr >= (32'd1 << AW);
                        has_op  = 1;
                        t_iss   = cyc;
                        t_end   = cyc + (m_op ? 2 : 2 + RL);
                        cool_cyc  = t_end + 1;
                        cool_line = (m_port ? 2 : 0) + (m_op ? 1 : 0);
                    end
                end
            end
            cyc++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int s0, v0, base;

    initial begin
        rstn = 1'b0; env_init = 1'b1; err_clr = 1'b0;
        cu_read_req = 1'b0; cu_write_req = 1'b0; host_read_req = 1'b0; host_write_req = 1'b0;
        cu_read_addr = 32'd0; cu_write_addr = 32'd0; cu_write_data = 32'd0;
        host_read_addr = 32'd0; host_write_addr = 32'd0; host_write_data = 32'd0;
        repeat (2) tick;
        env_init = 1'b0;
        tick;
        rstn = 1'b1;

        // CU write then read-back of the same word
        tick;
        cu_write_req = 1'b1; cu_write_addr = 32'h10; cu_write_data = 32'hA5A5_0001;
        tick;
        @(negedge clk);
        chk("w_en", 32'(sram_en), 32'd1);
        chk("w_we", 32'(sram_we), 32'd1);
        chk("w_addr", 32'(sram_addr), 32'h010);
        tick;
        @(negedge clk);
        chk("w_ack", 32'(cu_write_ack), 32'd1);
        tick;
        cu_write_req = 1'b0; cu_read_req = 1'b1; cu_read_addr = 32'h10;
        repeat (5) tick;
        @(negedge clk);
        chk("r_valid", 32'(cu_read_valid), 32'd1);
        chk("r_data", cu_read_data, 32'hA5A5_0001);
        tick;
        cu_read_req = 1'b0;

        // Host read with three-cycle SRAM latency: busy spans issue through response
        tick;
        host_read_req = 1'b1; host_read_addr = 32'h7FF; s0 = n_strobe;
        for (int k = 1; k <= 5; k++) begin
            tick;
            @(negedge clk);
            chk("h_busy", 32'(busy), 32'd1);
        end
        chk("h_valid", 32'(host_read_valid), 32'd1);
        chk("h_data", host_read_data, 32'h5A00_07FF);
        tick;
        host_read_req = 1'b0;
        @(negedge clk);
        chk("h_strobes", 32'(n_strobe - s0), 32'd1);
        chk("h_idle", 32'(busy), 32'd0);

        // Continuous contention from reset alternates CU, host, CU, host
        rstn = 1'b0;
        tick; tick;
        rstn = 1'b1;
        base = order.size();
        cu_read_req = 1'b1; cu_read_addr = 32'h20;
        host_read_req = 1'b1; host_read_addr = 32'h30;
        repeat (26) tick;
        cu_read_req = 1'b0; host_read_req = 1'b0;
        repeat (8) tick;
        chk("rr_count", 32'(order.size() - base >= 4), 32'd1);
        if (order.size() - base >= 4) begin
            chk("rr_0", 32'(order[base]), 32'd0);
            chk("rr_1", 32'(order[base+1]), 32'd1);
            chk("rr_2", 32'(order[base+2]), 32'd0);
            chk("rr_3", 32'(order[base+3]), 32'd1);
        end

        // Out-of-range write and read, clear, then set-wins-over-clear
        cu_write_req = 1'b1; cu_write_addr = 32'h0000_1000; cu_write_data = 32'hFFFF_0000; s0 = n_strobe;
        tick; tick;
        @(negedge clk);
        chk("oor_ack", 32'(cu_write_ack), 32'd1);
        chk("oor_err", 32'(err), 32'd1);
        tick;
        cu_write_req = 1'b0; cu_read_req = 1'b1; cu_read_addr = 32'h0000_1000;
        repeat (5) tick;
        @(negedge clk);
        chk("oor_rvalid", 32'(cu_read_valid), 32'd1);
        chk("oor_rdata", cu_read_data, 32'd0);
        chk("oor_nostrobe", 32'(n_strobe - s0), 32'd0);
        tick;
        cu_read_req = 1'b0; err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        tick;
        host_write_req = 1'b1; host_write_addr = 32'h8000_0000; host_write_data = 32'd1; err_clr = 1'b1;
        tick; tick;
        @(negedge clk);
        chk("setwins_err", 32'(err), 32'd1);
        chk("setwins_ack", 32'(host_write_ack), 32'd1);
        tick;
        host_write_req = 1'b0;
        @(negedge clk);
        chk("setwins_clr", 32'(err), 32'd0);
        tick;
        err_clr = 1'b0;

        // CU keeps its read request one cycle past the valid pulse
        tick;
        cu_read_req = 1'b1; cu_read_addr = 32'h10; s0 = n_strobe; v0 = n_cuv;
        repeat (5) tick;
        @(negedge clk);
        chk("hold_valid", 32'(cu_read_valid), 32'd1);
        chk("hold_data", cu_read_data, 32'hA5A5_0001);
        tick; tick;
        cu_read_req = 1'b0;
        repeat (8) tick;
        chk("hold_strobes", 32'(n_strobe - s0), 32'd1);
        chk("hold_valids", 32'(n_cuv - v0), 32'd1);

        // Reset while a host read waits on the SRAM
        v0 = n_hv;
        host_read_req = 1'b1; host_read_addr = 32'h40;
        tick; tick;
        rstn = 1'b0; host_read_req = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_en", 32'(sram_en), 32'd0);
        tick; tick;
        rstn = 1'b1;
        repeat (8) tick;
        chk("mid_novalid", 32'(n_hv - v0), 32'd0);
        host_write_req = 1'b1; host_write_addr = 32'h40; host_write_data = 32'h1234_5678;
        tick; tick;
        @(negedge clk);
        chk("post_wack", 32'(host_write_ack), 32'd1);
        tick;
        host_write_req = 1'b0; host_read_req = 1'b1;
        repeat (5) tick;
        @(negedge clk);
        chk("post_rvalid", 32'(host_read_valid), 32'd1);
        chk("post_rdata", host_read_data, 32'h1234_5678);
        tick;
        host_read_req = 1'b0;
        repeat (4) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
